// File: rtl/p2s_pkg.sv
// Shared types and defaults for the parallel-to-serial convertor.
package p2s_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   localparam int WIDTH_DEF = 32;
   localparam int LANES_DEF = 4;

   function automatic int idx_w(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

   localparam int IDX_W_DEF = idx_w(LANES_DEF);

endpackage

// File: rtl/p2s_lane_counter.sv
// Lane index counter: clear to 0, advance with wrap, flags the last lane.
module p2s_lane_counter
   import p2s_pkg::*;
#(
   parameter int LANES = LANES_DEF,
   parameter int IDX_W = idx_w(LANES)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             advance,
   output logic [IDX_W-1:0] idx,
   output logic [IDX_W-1:0] idx_nxt,
   output logic             last
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_d;

   always_comb begin
      idx_d = idx_q;
      if (clear) begin
         idx_d = '0;
      end else if (advance) begin
         idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

   assign idx     = idx_q;
   assign idx_nxt = idx_d;
   assign last    = (idx_q == LAST_IDX);

endmodule

// File: rtl/parallel_to_serial_convertor.sv
// Captures a frame of LANES words on one load handshake and streams them
// out lane 0 first with valid/ready flow control; reload on the last beat avoids bubbles.
module parallel_to_serial_convertor
   import p2s_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int LANES = LANES_DEF
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [LANES*WIDTH-1:0] par_data,
   input  logic                   load_valid,
   output logic                   load_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_valid,
   output logic                   out_last,
   input  logic                   out_ready
);

   localparam int IDX_W = idx_w(LANES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

   state_e                 state_q, state_d;
   logic [LANES*WIDTH-1:0] frame_q, frame_d;
   logic [WIDTH-1:0]       out_data_q, out_data_d;
   logic                   out_valid_q, out_valid_d;
   logic                   out_last_q, out_last_d;

   logic             cnt_clear;
   logic             cnt_advance;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nxt;
   logic             idx_last;
   logic             load_fire;
   logic [WIDTH-1:0] lane_w [LANES];

   p2s_lane_counter #(
      .LANES (LANES),
      .IDX_W (IDX_W)
   ) u_lane_counter (
      .clock   (clock),
      .reset   (reset),
      .clear   (cnt_clear),
      .advance (cnt_advance),
      .idx     (idx),
      .idx_nxt (idx_nxt),
      .last    (idx_last)
   );

   assign load_ready = (state_q == IDLE) || (idx_last && out_ready);
   assign load_fire  = load_valid && load_ready;

   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      cnt_clear   = 1'b0;
      cnt_advance = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_fire) begin
               state_d   = SHIFT;
               frame_d   = par_data;
               cnt_clear = 1'b1;
            end
         end
         SHIFT: begin
            if (out_ready) begin
               if (!idx_last) begin
                  cnt_advance = 1'b1;
               end else if (load_fire) begin
                  frame_d   = par_data;
                  cnt_clear = 1'b1;
               end else begin
                  state_d   = IDLE;
                  cnt_clear = 1'b1;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            cnt_clear = 1'b1;
         end
      endcase
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign lane_w[i] = frame_d[i*WIDTH +: WIDTH];
   end

   // Outputs are registered from the next-state view so they change only on edges.
   always_comb begin
      out_valid_d = (state_d == SHIFT);
      out_data_d  = out_valid_d ? lane_w[idx_nxt] : '0;
      out_last_d  = out_valid_d && (idx_nxt == LAST_IDX);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         frame_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_q     <= frame_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_parallel_to_serial_convertor.sv
// Directed bench for parallel_to_serial_convertor with hand-computed expectations.
module tb_parallel_to_serial_convertor;

   localparam int WIDTH = 32;
   localparam int LANES = 4;

   logic                   clock;
   logic                   reset;
   logic [LANES*WIDTH-1:0] par_data;
   logic                   load_valid;
   logic                   load_ready;
   logic [WIDTH-1:0]       out_data;
   logic                   out_valid;
   logic                   out_last;
   logic                   out_ready;

   int asserts_n;
   int fails_n;

   parallel_to_serial_convertor #(
      .WIDTH (WIDTH),
      .LANES (LANES)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .par_data   (par_data),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_last   (out_last),
      .out_ready  (out_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [LANES*WIDTH-1:0] mk(input logic [31:0] l0, input logic [31:0] l1,
                                                  input logic [31:0] l2, input logic [31:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; load_valid = 1'b1; out_ready = 1'b1;
      par_data = mk(32'd9, 32'd9, 32'd9, 32'd9);
      step(); step();
      asserts_n++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0) begin
         fails_n++;
         $display("FAIL reset_outputs: got valid=%b data=%h last=%b, want 0 0 0", out_valid, out_data, out_last);
      end
      load_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      asserts_n++;
      if (load_ready !== 1'b1) begin
         fails_n++;
         $display("FAIL reset_load_ready: got %b, want 1", load_ready);
      end
   endtask

   task automatic test_single_frame();
      logic [31:0] exp_w [4];
      exp_w = '{32'd3, 32'd4, 32'd5, 32'd2};
      par_data = mk(32'd3, 32'd4, 32'd5, 32'd2);
      load_valid = 1'b1; out_ready = 1'b1;
      step();
      load_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         asserts_n++;
         if (out_valid !== 1'b1 || out_data !== exp_w[k] || out_last !== (k == 3)) begin
            fails_n++;
            $display("FAIL single_word%0d: got valid=%b data=%0d last=%b, want 1 %0d %b",
                     k, out_valid, out_data, out_last, exp_w[k], (k == 3));
         end
         step();
      end
      asserts_n++;
      if (out_valid !== 1'b0 || out_data !== '0 || load_ready !== 1'b1) begin
         fails_n++;
         $display("FAIL single_idle: got valid=%b data=%h ready=%b, want 0 0 1", out_valid, out_data, load_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_w [8];
      exp_w = '{32'd3, 32'd4, 32'd5, 32'd2, 32'd1, 32'd8, 32'd2, 32'h04000004};
      par_data = mk(32'd3, 32'd4, 32'd5, 32'd2);
      load_valid = 1'b1; out_ready = 1'b1;
      step();
      par_data = mk(32'd1, 32'd8, 32'd2, 32'h04000004);
      for (int k = 0; k < 8; k++) begin
         asserts_n++;
         if (out_valid !== 1'b1 || out_data !== exp_w[k] || out_last !== (k % 4 == 3)) begin
            fails_n++;
            $display("FAIL b2b_word%0d: got valid=%b data=%h last=%b, want 1 %h %b",
                     k, out_valid, out_data, out_last, exp_w[k], (k % 4 == 3));
         end
         if (k < 4) begin
            asserts_n++;
            if (load_ready !== (k == 3)) begin
               fails_n++;
               $display("FAIL b2b_ready%0d: got %b, want %b", k, load_ready, (k == 3));
            end
         end
         if (k == 4) load_valid = 1'b0;
         step();
      end
      asserts_n++;
      if (out_valid !== 1'b0) begin
         fails_n++;
         $display("FAIL b2b_end_valid: got %b, want 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      par_data = mk(32'd3, 32'd4, 32'd5, 32'd2);
      load_valid = 1'b1; out_ready = 1'b1;
      step();
      load_valid = 1'b0;
      step();
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         asserts_n++;
         if (out_valid !== 1'b1 || out_data !== 32'd4 || load_ready !== 1'b0 || out_last !== 1'b0) begin
            fails_n++;
            $display("FAIL bp_hold%0d: got valid=%b data=%0d ready=%b last=%b, want 1 4 0 0",
                     c, out_valid, out_data, load_ready, out_last);
         end
      end
      out_ready = 1'b1;
      step();
      asserts_n++;
      if (out_data !== 32'd5 || out_valid !== 1'b1) begin
         fails_n++;
         $display("FAIL bp_resume: got data=%0d valid=%b, want 5 1", out_data, out_valid);
      end
      step();
      asserts_n++;
      if (out_data !== 32'd2 || out_last !== 1'b1) begin
         fails_n++;
         $display("FAIL bp_last: got data=%0d last=%b, want 2 1", out_data, out_last);
      end
      step();
   endtask

   task automatic test_par_data_change();
      logic [31:0] exp_w [4];
      exp_w = '{32'd3, 32'd4, 32'd5, 32'd2};
      par_data = mk(32'd3, 32'd4, 32'd5, 32'd2);
      load_valid = 1'b1; out_ready = 1'b1;
      step();
      load_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         par_data = mk($urandom | 32'h100, $urandom | 32'h100, $urandom | 32'h100, $urandom | 32'h100);
         asserts_n++;
         if (out_data !== exp_w[k]) begin
            fails_n++;
            $display("FAIL capture_word%0d: got %h, want %h", k, out_data, exp_w[k]);
         end
         step();
      end
   endtask

   task automatic test_reset_mid_frame();
      par_data = mk(32'd3, 32'd4, 32'd5, 32'd2);
      load_valid = 1'b1; out_ready = 1'b1;
      step();
      load_valid = 1'b0;
      step();
      asserts_n++;
      if (out_data !== 32'd4) begin
         fails_n++;
         $display("FAIL midrst_lane1: got %0d, want 4", out_data);
      end
      reset = 1'b1;
      #1;
      asserts_n++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0) begin
         fails_n++;
         $display("FAIL midrst_async: got valid=%b data=%h last=%b, want 0 0 0", out_valid, out_data, out_last);
      end
      @(negedge clock);
      reset = 1'b0;
      step();
      asserts_n++;
      if (load_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails_n++;
         $display("FAIL midrst_after: got ready=%b valid=%b, want 1 0", load_ready, out_valid);
      end
   endtask

   task automatic test_loopback();
      logic [31:0] d [4];
      logic [31:0] exp_w [4];
      int          n;
      bit          done;
      exp_w = '{32'd3, 32'd4, 32'd5, 32'd2};
      d = '{default: '0};
      n = 0; done = 0;
      par_data = mk(32'd3, 32'd4, 32'd5, 32'd2);
      load_valid = 1'b1; out_ready = 1'b1;
      step();
      load_valid = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         if (out_valid && out_ready) begin
            if (n < 4) d[n] = out_data;
            n++;
            if (out_last) done = 1;
         end
         step();
      end
      asserts_n++;
      if (!done || n != 4) begin
         fails_n++;
         $display("FAIL loop_frame: got done=%0d words=%0d, want 1 4", done, n);
      end
      for (int i = 0; i < 4; i++) begin
         asserts_n++;
         if (d[i] !== exp_w[i]) begin
            fails_n++;
            $display("FAIL loop_d%0d: got %0d, want %0d", i, d[i], exp_w[i]);
         end
      end
   endtask

   initial begin
      asserts_n = 0;
      fails_n = 0;
      reset = 1'b0; load_valid = 1'b0; out_ready = 1'b0; par_data = '0;
      #2;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_backpressure();
      test_par_data_change();
      test_reset_mid_frame();
      test_loopback();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts_n, fails_n);
      $finish;
   end

endmodule
